// File: rtl/fixed_sigmoid_lut_loader.sv
// Streamed-load lookup table with P parallel read lanes and a one-entry output register.
// Define FIXED_SIGMOID_LUT_CHECKSUM_EN to add a 16-bit running sum of the loaded words.

module fixed_sigmoid_lut_loader #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic lut_load_start,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_wdata,
  input  logic lut_wdata_valid,
  output logic lut_wdata_ready,
  output logic lut_loaded,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready
`ifdef FIXED_SIGMOID_LUT_CHECKSUM_EN
  ,
  output logic [15:0] lut_checksum
`endif
);

  // state | meaning
  // EMPTY | no table resident, waiting for lut_load_start
  // LOAD  | accepting table words at wr_ptr
  // RUN   | table resident, serving lookups
  // DRAIN | reload requested, waiting for pending output to leave

  localparam int IW       = DATA_IN_0_PRECISION_0;
  localparam int OW       = DATA_OUT_0_PRECISION_0;
  localparam int P        = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int MEM_SIZE = 2 ** IW;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   wr_ptr;
  logic [OW-1:0]   table_mem [MEM_SIZE];
  logic [P*OW-1:0] lookup;
  logic            out_free;
  logic            in_hs;
  logic            wr_hs;
  logic            enter_load;

  assign out_free        = !data_out_0_valid || data_out_0_ready;
  assign lut_wdata_ready = (state == LOAD);
  assign data_in_0_ready = (state == RUN) && !lut_load_start && out_free;
  assign in_hs           = data_in_0_valid && data_in_0_ready;
  assign wr_hs           = lut_wdata_valid && lut_wdata_ready;

  // Going straight to LOAD when the pending output leaves in the same cycle
  // keeps DRAIN from waiting on an output that is already gone.
  assign enter_load = ((state == EMPTY) && lut_load_start) ||
                      ((state == RUN) && lut_load_start && out_free) ||
                      ((state == DRAIN) && out_free);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      wr_ptr     <= '0;
      lut_loaded <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (lut_load_start) state <= LOAD;
        LOAD: begin
          if (wr_hs) begin
            wr_ptr <= wr_ptr + IW'(1);
            if (wr_ptr == '1) begin
              state      <= RUN;
              lut_loaded <= 1'b1;
            end
          end
        end
        RUN:   if (lut_load_start) state <= out_free ? LOAD : DRAIN;
        DRAIN: if (out_free) state <= LOAD;
        default: state <= EMPTY;
      endcase
      if (enter_load) begin
        wr_ptr     <= '0;
        lut_loaded <= 1'b0;
      end
    end
  end

  // Table contents survive reset; only the write handshake changes them.
  always_ff @(posedge clk) begin
    if (rst && wr_hs) table_mem[wr_ptr] <= lut_wdata;
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    assign lookup[i*OW +: OW] = table_mem[data_in_0[i*IW +: IW]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_0       <= '0;
      data_out_0_valid <= 1'b0;
    end else if (in_hs) begin
      data_out_0       <= lookup;
      data_out_0_valid <= 1'b1;
    end else if (data_out_0_valid && data_out_0_ready) begin
      data_out_0_valid <= 1'b0;
    end
  end

`ifdef FIXED_SIGMOID_LUT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst || enter_load) lut_checksum <= '0;
    else if (wr_hs)         lut_checksum <= lut_checksum + 16'(lut_wdata);
  end
`endif

endmodule

// File: tb/tb_fixed_sigmoid_lut_loader.sv
// Scoreboard bench for fixed_sigmoid_lut_loader at default parameters (P=1, 256 entries).
// Honors FIXED_SIGMOID_LUT_CHECKSUM_EN for the checksum check.

module tb_fixed_sigmoid_lut_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lut_load_start = 1'b0;
  logic [7:0] lut_wdata = '0;
  logic       lut_wdata_valid = 1'b0;
  logic       lut_wdata_ready;
  logic       lut_loaded;
  logic [7:0] data_in_0 = '0;
  logic       data_in_0_valid = 1'b0;
  logic       data_in_0_ready;
  logic [7:0] data_out_0;
  logic       data_out_0_valid;
  logic       data_out_0_ready = 1'b1;
`ifdef FIXED_SIGMOID_LUT_CHECKSUM_EN
  logic [15:0] lut_checksum;
`endif

  fixed_sigmoid_lut_loader dut (
    .clk              (clk),
    .rst              (rst),
    .lut_load_start   (lut_load_start),
    .lut_wdata        (lut_wdata),
    .lut_wdata_valid  (lut_wdata_valid),
    .lut_wdata_ready  (lut_wdata_ready),
    .lut_loaded       (lut_loaded),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
`ifdef FIXED_SIGMOID_LUT_CHECKSUM_EN
    ,
    .lut_checksum     (lut_checksum)
`endif
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  model [256];
  logic [15:0] csum_model = '0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: w[i]=255-i, mode 1: w[i]=i
  task automatic load_words(input bit pulse, input int n, input int mode, input bit gaps);
    logic [7:0] v;
    bit got;
    csum_model = '0;
    if (pulse) begin
      lut_load_start = 1'b1;
      tick();
      lut_load_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        lut_wdata_valid = 1'b0;
        tick();
      end
      v = (mode == 0) ? 8'(255 - i) : 8'(i);
      lut_wdata = v;
      lut_wdata_valid = 1'b1;
      got = 1'b0;
      for (int b = 0; b < 50 && !got; b++) begin
        #1;
        got = lut_wdata_ready;
        if (got && i == 255) begin
          n_total++;
          if (lut_loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL loaded_before_last: got %b want 0", lut_loaded);
          end
        end
        @(posedge clk);
        #1;
      end
      if (!got) begin
        n_total++;
        n_bad++;
        $display("FAIL load_timeout: word %0d not accepted, want ready=1", i);
        lut_wdata_valid = 1'b0;
        return;
      end
      model[i] = v;
      csum_model = csum_model + 16'(v);
    end
    lut_wdata_valid = 1'b0;
    if (n == 256) begin
      n_total++;
      if (lut_loaded !== 1'b1) begin
        n_bad++;
        $display("FAIL loaded_after_last: got %b want 1", lut_loaded);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({data_out_0_valid, lut_loaded, lut_wdata_ready, data_in_0_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000",
               {data_out_0_valid, lut_loaded, lut_wdata_ready, data_in_0_ready});
    end
    rst = 1'b1;
    tick();
    data_in_0 = 8'h10;
    data_in_0_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_total++;
      if ({data_in_0_ready, lut_loaded, data_out_0_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL empty_idle c%0d: ready/loaded/valid=%b want 000", c,
                 {data_in_0_ready, lut_loaded, data_out_0_valid});
      end
      @(posedge clk);
      #1;
    end
    data_in_0_valid = 1'b0;
  endtask

  task automatic test_load();
    load_words(1'b1, 256, 0, 1'b1);
    n_total++;
    if (lut_wdata_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wready_in_run: got %b want 0", lut_wdata_ready);
    end
  endtask

  task automatic test_lookup();
    data_out_0_ready = 1'b1;
    data_in_0 = 8'h10;
    data_in_0_valid = 1'b1;
    #1;
    n_total++;
    if (data_in_0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lookup_ready: got %b want 1", data_in_0_ready);
    end
    exp_q.push_back(model[8'h10]);
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL lookup_0x10: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
    n_total++;
    if (data_out_0_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lookup_clear: valid got %b want 0", data_out_0_valid);
    end
  endtask

  task automatic test_back_to_back();
    data_out_0_ready = 1'b1;
    data_in_0 = 8'h00;
    data_in_0_valid = 1'b1;
    exp_q.push_back(model[8'h00]);
    tick();
    data_in_0 = 8'hFF;
    #1;
    n_total++;
    if (data_in_0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %b want 1", data_in_0_ready);
    end
    exp_q.push_back(model[8'hFF]);
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_first: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
  endtask

  task automatic test_stall();
    data_out_0_ready = 1'b0;
    data_in_0 = 8'h10;
    data_in_0_valid = 1'b1;
    exp_q.push_back(model[8'h10]);
    tick();
    data_in_0 = 8'h20;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_q[0] || data_in_0_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold c%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", c,
                 data_out_0_valid, data_out_0, data_in_0_ready, exp_q[0]);
      end
      @(posedge clk);
      #1;
    end
    data_out_0_ready = 1'b1;
    #1;
    n_total++;
    if (data_in_0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release_ready: got %b want 1", data_in_0_ready);
    end
    exp_v = exp_q.pop_front();
    exp_q.push_back(model[8'h20]);
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL stall_next: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
  endtask

  task automatic test_reload_drain();
    data_out_0_ready = 1'b0;
    data_in_0 = 8'h10;
    data_in_0_valid = 1'b1;
    exp_q.push_back(model[8'h10]);
    tick();
    data_in_0 = 8'h30;
    lut_load_start = 1'b1;
    #1;
    n_total++;
    if (data_in_0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL start_blocks_input: ready got %b want 0", data_in_0_ready);
    end
    @(posedge clk);
    #1;
    lut_load_start = 1'b0;
    data_in_0_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_q[0] || lut_wdata_ready !== 1'b0 ||
          lut_loaded !== 1'b1 || data_in_0_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL drain_hold c%0d: got v=%b d=%h wrdy=%b ld=%b irdy=%b want 1 %h 0 1 0", c,
                 data_out_0_valid, data_out_0, lut_wdata_ready, lut_loaded, data_in_0_ready, exp_q[0]);
      end
      @(posedge clk);
      #1;
    end
    data_out_0_ready = 1'b1;
    exp_v = exp_q.pop_front();
    tick();
    n_total++;
    if (lut_wdata_ready !== 1'b1 || lut_loaded !== 1'b0 || data_out_0_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_to_load: got wrdy=%b ld=%b v=%b want 1 0 0",
               lut_wdata_ready, lut_loaded, data_out_0_valid);
    end
    load_words(1'b0, 256, 1, 1'b0);
    data_in_0 = 8'h10;
    data_in_0_valid = 1'b1;
    exp_q.push_back(model[8'h10]);
    tick();
    data_in_0_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL reload_lookup: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    load_words(1'b1, 100, 0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_total++;
    if (lut_loaded !== 1'b0 || lut_wdata_ready !== 1'b0 || data_in_0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midload_reset: got ld=%b wrdy=%b irdy=%b want 0 0 0",
               lut_loaded, lut_wdata_ready, data_in_0_ready);
    end
    lut_wdata_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (lut_wdata_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL empty_no_load c%0d: wready got %b want 0", c, lut_wdata_ready);
      end
      @(posedge clk);
      #1;
    end
    lut_wdata_valid = 1'b0;
    load_words(1'b1, 256, 1, 1'b0);
`ifdef FIXED_SIGMOID_LUT_CHECKSUM_EN
    n_total++;
    if (lut_checksum !== csum_model) begin
      n_bad++;
      $display("FAIL checksum: got %h want %h", lut_checksum, csum_model);
    end
`endif
    data_out_0_ready = 1'b1;
    data_in_0 = 8'h00;
    data_in_0_valid = 1'b1;
    exp_q.push_back(model[8'h00]);
    tick();
    data_in_0 = 8'hFF;
    exp_q.push_back(model[8'hFF]);
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL fresh_load_0x00: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
    data_in_0_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_total++;
    if (data_out_0_valid !== 1'b1 || data_out_0 !== exp_v) begin
      n_bad++;
      $display("FAIL fresh_load_0xFF: got v=%b d=%h want v=1 d=%h", data_out_0_valid, data_out_0, exp_v);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_lookup();
    test_back_to_back();
    test_stall();
    test_reload_drain();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_sigmoid_lut_loader.md
FIXED_SIGMOID_LUT_LOADER -- requirements
Module: fixed_sigmoid_lut_loader

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: lookup index width; the table holds MEM_SIZE = 2**DATA_IN_0_PRECISION_0 entries.
REQ-002 SHALL have parameter DATA_OUT_0_PRECISION_0, default 8: table entry width and output width.
REQ-003 SHALL have parameter DATA_IN_0_PARALLELISM_DIM_0, default 1, and DATA_IN_0_PARALLELISM_DIM_1, default 1; lane count P is their product.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register is rising-edge clocked.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port lut_load_start, input, 1 bit: single-cycle request to (re)load the table.
REQ-007 SHALL have ports lut_wdata (input, DATA_OUT_0_PRECISION_0 bits), lut_wdata_valid (input, 1 bit) and lut_wdata_ready (output, 1 bit): the table-word stream.
REQ-008 SHALL have port lut_loaded, output, 1 bit: high when a complete table is resident.
REQ-009 SHALL have ports data_in_0 (input, P x DATA_IN_0_PRECISION_0 bits), data_in_0_valid (input, 1 bit) and data_in_0_ready (output, 1 bit): the lookup index stream.
REQ-010 SHALL have ports data_out_0 (output, P x DATA_OUT_0_PRECISION_0 bits), data_out_0_valid (output, 1 bit) and data_out_0_ready (input, 1 bit): the lookup result stream.

Function
REQ-011 SHALL implement a state machine with states EMPTY, LOAD, RUN and DRAIN.
REQ-012 EMPTY SHALL go to LOAD on lut_load_start; it SHALL hold lut_wdata_ready=0, data_in_0_ready=0 and lut_loaded=0.
REQ-013 In LOAD, lut_wdata_ready SHALL be 1, and each lut_wdata handshake SHALL write the entry at the write pointer and increment the pointer.
REQ-014 On the handshake at write pointer MEM_SIZE-1, the pointer SHALL wrap to 0 and the state SHALL move to RUN; lut_loaded SHALL be 1 from the next cycle.
REQ-015 lut_load_start SHALL be ignored while in LOAD or DRAIN.
REQ-016 A handshake on lut_wdata outside LOAD SHALL be impossible, because lut_wdata_ready is 0 there.
REQ-017 In RUN, data_in_0_ready SHALL equal !data_out_0_valid || data_out_0_ready; a one-entry output register SHALL give exactly 1 cycle of latency.
REQ-018 On each input handshake, the output register SHALL load data_out_0[i] = table[data_in_0[i]] for every lane i and set data_out_0_valid.
REQ-019 data_out_0_valid SHALL clear after an output handshake that has no simultaneous input handshake.
REQ-020 While data_out_0_valid=1 and data_out_0_ready=0, data_out_0 and data_out_0_valid SHALL hold stable.
REQ-021 If lut_load_start arrives in RUN, data_in_0_ready SHALL drop in that same cycle, and the input handshake in that cycle SHALL NOT occur.
REQ-022 After a lut_load_start in RUN, the state SHALL go to LOAD if the output register is empty; otherwise it SHALL go to DRAIN.
REQ-023 DRAIN SHALL hold data_in_0_ready=0 and SHALL go to LOAD on the cycle the pending output completes its handshake.
REQ-024 lut_loaded SHALL drop on entry to LOAD; entries not yet rewritten SHALL keep their old values but SHALL NOT be readable until RUN.
REQ-025 Table storage SHALL be a register array with a single write port and P combinational read ports; it SHALL have no initial file load.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL enter EMPTY and clear the write pointer.
REQ-027 Reset SHALL drive data_out_0_valid=0, lut_loaded=0, lut_wdata_ready=0 and data_in_0_ready=0.
REQ-028 Reset SHALL NOT clear table contents.
REQ-029 A reset in the middle of a load SHALL discard the partial load; a new lut_load_start is then required.

Configuration
REQ-030 With macro FIXED_SIGMOID_LUT_CHECKSUM_EN defined, the block SHALL add output lut_checksum, 16 bits.
REQ-031 lut_checksum SHALL be cleared on entry to LOAD and on reset, and SHALL accumulate the sum modulo 2**16 of every lut_wdata word accepted.
REQ-032 lut_checksum SHALL hold its value in all other states.
REQ-033 With FIXED_SIGMOID_LUT_CHECKSUM_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults, P=1, MEM_SIZE=256)
REQ-034 The bench SHALL check: after reset, drive data_in_0_valid=1, index 0x10 -> data_in_0_ready=0, lut_loaded=0, no output for 20 cycles.
REQ-035 The bench SHALL check: pulse lut_load_start, stream 256 words w[i]=255-i with gaps -> lut_loaded=1 the cycle after the 256th handshake; index 0x10 -> data_out_0=0xEF, valid exactly 1 cycle later.
REQ-036 The bench SHALL check: back-to-back indices 0x00, 0xFF with data_out_0_ready=1 -> outputs 0xFF, 0x00 on consecutive cycles.
REQ-037 The bench SHALL check: hold data_out_0_ready=0 with 0xEF pending -> 0xEF held stable and data_in_0_ready=0; release -> 0xEF consumed and the next index is accepted the same cycle.
REQ-038 The bench SHALL check: lut_load_start while output 0xEF is stalled -> DRAIN until 0xEF is consumed, then LOAD with lut_loaded=0; after reloading w[i]=i, index 0x10 -> 0x10.
REQ-039 The bench SHALL check: reset after 100 load words -> EMPTY, lut_loaded=0; with the macro defined, a full load of w[i]=i -> lut_checksum=0x7F80.
